// File: rtl/rv32_types_pkg.sv
// Shared RV32 data-port types: memory operation encoding and the request bundle
// driven by the memory stage, plus small op-classification helpers.
package rv32_types_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    typedef struct packed {
        logic [31:0] addr;
        mem_op_t     op;
        logic [31:0] data;
    } memory_request_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_half(input mem_op_t op);
        return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    endfunction

    function automatic logic is_word(input mem_op_t op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/rv32_byte_sram.sv
// Single-port data RAM: one-cycle synchronous read, per-byte write enables.
module rv32_byte_sram #(
    parameter int unsigned WORDS     = 16384,
    parameter int unsigned AW        = $clog2(WORDS),
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the array and read register carry no reset; contents survive resetn.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rv32_data_mem_responder.sv
// Responder for the core's data-memory port: accepts one request, waits LATENCY
// cycles, performs the checked RAM access and pulses request_done for one cycle.
module rv32_data_mem_responder
    import rv32_types_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned LATENCY   = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            resetn,
    input  memory_request_t data_request,
    output logic            request_done,
    output logic [31:0]     load_data,
    output logic            access_fault,
    output logic            misaligned
);

    localparam int unsigned AW     = $clog2(MEM_WORDS);
    localparam logic [32:0] WINDOW = 33'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    memory_request_t req_q, req_d;
    logic            fault_q, fault_d;
    logic            misal_q, misal_d;

    logic [31:0]     offset;
    logic            addr_fault;
    logic            addr_misal;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;

    function automatic logic [3:0] store_we(input mem_op_t op, input logic [1:0] lane);
        logic [3:0] we;
        case (op)
            MEM_SB:  we = 4'b0001 << lane;
            MEM_SH:  we = lane[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] store_wdata(input mem_op_t op, input logic [31:0] data);
        logic [31:0] w;
        case (op)
            MEM_SB:  w = {4{data[7:0]}};
            MEM_SH:  w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input mem_op_t op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  r = {{24{b[7]}}, b};
            MEM_LBU: r = {24'h0, b};
            MEM_LH:  r = {{16{h[15]}}, h};
            MEM_LHU: r = {16'h0, h};
            MEM_LW:  r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Offset wraps for addresses below BASE_ADDR, so a single compare covers both sides.
    assign offset     = req_q.addr - BASE_ADDR;
    assign addr_fault = {1'b0, offset} >= WINDOW;
    assign addr_misal = (is_half(req_q.op) && req_q.addr[0]) ||
                        (is_word(req_q.op) && (req_q.addr[1:0] != 2'b00));

    assign ram_en    = resetn && (state_q == BUSY) && (cnt_q == 4'd0) && !addr_fault && !addr_misal;
    assign ram_we    = is_store(req_q.op) ? store_we(req_q.op, req_q.addr[1:0]) : 4'b0000;
    assign ram_wdata = store_wdata(req_q.op, req_q.data);

    rv32_byte_sram #(
        .WORDS     (MEM_WORDS),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (offset[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            fault_q <= 1'b0;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            misal_q <= misal_d;
        end
    end

    // NOTE: every combinational output is defaulted first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        fault_d = fault_q;
        misal_d = misal_q;
        case (state_q)
            IDLE: begin
                if (data_request.op != MEM_NOP) begin
                    req_d   = data_request;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    fault_d = addr_fault;
                    misal_d = !addr_fault && addr_misal;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        request_done = (state_q == DONE);
        access_fault = request_done && fault_q;
        misaligned   = request_done && misal_q;
        load_data    = 32'h0;
        if (request_done && !fault_q && !misal_q && !is_store(req_q.op)) begin
            load_data = load_extend(req_q.op, req_q.addr[1:0], ram_rdata);
        end
    end

    a_request_stable: assert property (@(posedge clk) disable iff (!resetn)
        (state_q != IDLE) |-> (data_request == req_q));

    a_done_single: assert property (@(posedge clk) disable iff (!resetn)
        request_done |=> !request_done);

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Scoreboarded bench: a LATENCY=1 instance for functional/boundary checks and a
// LATENCY=3 offset-window instance for streaming, window limits and reset abort.
module tb_rv32_data_mem_responder;
    import rv32_types_pkg::*;

    typedef struct {
        logic [31:0] data;
        bit          fault;
        bit          mis;
    } exp_t;

    logic            clk = 1'b0;
    logic            resetn1, resetn3;
    memory_request_t req1, req3;
    logic            done1, done3;
    logic [31:0]     load1, load3;
    logic            fault1, fault3;
    logic            mis1, mis3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt1 = 0, done_cnt3 = 0;
    int en_cnt1 = 0, en_cnt3 = 0;
    int last_done_cyc;
    exp_t exp_q[$];
    logic [7:0] mdl [logic [31:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done1) done_cnt1++;
        if (done3) done_cnt3++;
        if (dut1.ram_en) en_cnt1++;
        if (dut3.ram_en) en_cnt3++;
    end

    rv32_data_mem_responder dut1 (
        .clk          (clk),
        .resetn       (resetn1),
        .data_request (req1),
        .request_done (done1),
        .load_data    (load1),
        .access_fault (fault1),
        .misaligned   (mis1)
    );

    rv32_data_mem_responder #(
        .MEM_WORDS (1024),
        .BASE_ADDR (32'h0000_1000),
        .LATENCY   (3)
    ) dut3 (
        .clk          (clk),
        .resetn       (resetn3),
        .data_request (req3),
        .request_done (done3),
        .load_data    (load3),
        .access_fault (fault3),
        .misaligned   (mis3)
    );

    function automatic memory_request_t mk(input mem_op_t op, input logic [31:0] addr,
                                           input logic [31:0] data);
        memory_request_t r;
        r.addr = addr;
        r.op   = op;
        r.data = data;
        return r;
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : 8'hxx;
    endfunction

    // Byte-addressed reference model of the LATENCY=3 instance's RAM.
    function automatic logic [31:0] mdl_exec(input memory_request_t r);
        logic [31:0] ha;
        logic [31:0] wa;
        ha = {r.addr[31:1], 1'b0};
        wa = {r.addr[31:2], 2'b00};
        case (r.op)
            MEM_SB: mdl[r.addr] = r.data[7:0];
            MEM_SH: begin
                mdl[ha]     = r.data[7:0];
                mdl[ha + 1] = r.data[15:8];
            end
            MEM_SW: for (int i = 0; i < 4; i++) mdl[wa + i] = r.data[8*i +: 8];
            MEM_LB:  return {{24{mdl_rd(r.addr)[7]}}, mdl_rd(r.addr)};
            MEM_LBU: return {24'h0, mdl_rd(r.addr)};
            MEM_LH:  return {{16{mdl_rd(ha + 1)[7]}}, mdl_rd(ha + 1), mdl_rd(ha)};
            MEM_LHU: return {16'h0, mdl_rd(ha + 1), mdl_rd(ha)};
            MEM_LW:  return {mdl_rd(wa + 3), mdl_rd(wa + 2), mdl_rd(wa + 1), mdl_rd(wa)};
            default: ;
        endcase
        return 32'h0;
    endfunction

    // Drive one request at the current negedge, wait for done, score it, then
    // check the pulse has dropped one cycle later.
    task automatic run_req(input bit sel, input memory_request_t r, input logic [31:0] exp_data,
                           input bit exp_fault, input bit exp_mis, input bit keep);
        exp_t e;
        int   n;
        bit   seen;
        int   want_lat;
        want_lat = sel ? 4 : 2;
        if (sel) req3 = r; else req1 = r;
        e.data  = exp_data;
        e.fault = exp_fault;
        e.mis   = exp_mis;
        exp_q.push_back(e);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (sel ? done3 : done1) begin
                seen = 1;
            end else begin
                checks++;
                if ((sel ? load3 : load1) !== 32'h0 || (sel ? fault3 : fault1) !== 1'b0 ||
                    (sel ? mis3 : mis1) !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_outputs dut%0d op=%0d: load=%h fault=%b mis=%b, want all zero",
                             sel ? 3 : 1, r.op, sel ? load3 : load1, sel ? fault3 : fault1, sel ? mis3 : mis1);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout dut%0d op=%0d addr=%h: no request_done within %0d cycles",
                     sel ? 3 : 1, r.op, r.addr, n);
        end else begin
            last_done_cyc = cyc;
            if (n !== want_lat) begin
                errors++;
                $display("FAIL latency dut%0d op=%0d addr=%h: got %0d cycles, want %0d",
                         sel ? 3 : 1, r.op, r.addr, n, want_lat);
            end
            checks++;
            if ((sel ? load3 : load1) !== e.data) begin
                errors++;
                $display("FAIL load_data dut%0d op=%0d addr=%h: got %h, want %h",
                         sel ? 3 : 1, r.op, r.addr, sel ? load3 : load1, e.data);
            end
            checks++;
            if ((sel ? fault3 : fault1) !== e.fault || (sel ? mis3 : mis1) !== e.mis) begin
                errors++;
                $display("FAIL flags dut%0d op=%0d addr=%h: got fault=%b mis=%b, want fault=%b mis=%b",
                         sel ? 3 : 1, r.op, r.addr, sel ? fault3 : fault1, sel ? mis3 : mis1,
                         e.fault, e.mis);
            end
        end
        @(negedge clk);
        checks++;
        if ((sel ? done3 : done1) !== 1'b0 || (sel ? fault3 : fault1) !== 1'b0 ||
            (sel ? mis3 : mis1) !== 1'b0 || (sel ? load3 : load1) !== 32'h0) begin
            errors++;
            $display("FAIL pulse_drop dut%0d op=%0d: done=%b fault=%b mis=%b load=%h after done, want all zero",
                     sel ? 3 : 1, r.op, sel ? done3 : done1, sel ? fault3 : fault1,
                     sel ? mis3 : mis1, sel ? load3 : load1);
        end
        if (!keep) begin
            if (sel) req3 = mk(MEM_NOP, 32'h0, 32'h0); else req1 = mk(MEM_NOP, 32'h0, 32'h0);
        end
    endtask

    task automatic test_reset();
        resetn1 = 1'b0;
        resetn3 = 1'b0;
        req1 = mk(MEM_NOP, 32'h0, 32'h0);
        req3 = mk(MEM_NOP, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if ({done1, fault1, mis1, done3, fault3, mis3} !== 6'b0 || load1 !== 32'h0 || load3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b/%b fault=%b/%b mis=%b/%b load=%h/%h, want all zero",
                     done1, done3, fault1, fault3, mis1, mis3, load1, load3);
        end
        checks++;
        if (2'(dut1.state_q) !== 2'd0 || 2'(dut3.state_q) !== 2'd0 ||
            dut1.cnt_q !== 4'd0 || dut3.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d/%0d cnt=%0d/%0d, want IDLE and 0",
                     dut1.state_q, dut3.state_q, dut1.cnt_q, dut3.cnt_q);
        end
        resetn1 = 1'b1;
        resetn3 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_done: done=%b/%b with NOP requests, want 0", done1, done3);
        end
    endtask

    task automatic test_word();
        run_req(0, mk(MEM_SW, 32'h10, 32'hDEAD_BEEF), 32'h0, 0, 0, 0);
        run_req(0, mk(MEM_LW, 32'h10, 32'h0), 32'hDEAD_BEEF, 0, 0, 0);
    endtask

    task automatic test_byte();
        run_req(0, mk(MEM_SB, 32'h13, 32'h0000_0080), 32'h0, 0, 0, 0);
        run_req(0, mk(MEM_LB, 32'h13, 32'h0), 32'hFFFF_FF80, 0, 0, 0);
        run_req(0, mk(MEM_LBU, 32'h13, 32'h0), 32'h0000_0080, 0, 0, 0);
        run_req(0, mk(MEM_LW, 32'h10, 32'h0), 32'h80AD_BEEF, 0, 0, 0);
        run_req(0, mk(MEM_LB, 32'h10, 32'h0), 32'hFFFF_FFEF, 0, 0, 0);
        run_req(0, mk(MEM_LBU, 32'h11, 32'h0), 32'h0000_00BE, 0, 0, 0);
    endtask

    task automatic test_half_misaligned();
        run_req(0, mk(MEM_SW, 32'h20, 32'hA5A5_A5A5), 32'h0, 0, 0, 0);
        run_req(0, mk(MEM_SH, 32'h22, 32'h0000_1234), 32'h0, 0, 0, 0);
        run_req(0, mk(MEM_LHU, 32'h22, 32'h0), 32'h0000_1234, 0, 0, 0);
        run_req(0, mk(MEM_LH, 32'h20, 32'h0), 32'hFFFF_A5A5, 0, 0, 0);
        run_req(0, mk(MEM_LH, 32'h21, 32'h0), 32'h0, 0, 1, 0);
        run_req(0, mk(MEM_SW, 32'h21, 32'hFFFF_FFFF), 32'h0, 0, 1, 0);
        run_req(0, mk(MEM_SH, 32'h23, 32'hFFFF_FFFF), 32'h0, 0, 1, 0);
        run_req(0, mk(MEM_LW, 32'h22, 32'h0), 32'h0, 0, 1, 0);
        run_req(0, mk(MEM_LW, 32'h20, 32'h0), 32'h1234_A5A5, 0, 0, 0);
    endtask

    task automatic test_fault();
        int en_before;
        run_req(0, mk(MEM_SW, 32'h0000_FFFC, 32'hCAFE_F00D), 32'h0, 0, 0, 0);
        run_req(0, mk(MEM_LW, 32'h0000_FFFC, 32'h0), 32'hCAFE_F00D, 0, 0, 0);
        en_before = en_cnt1;
        run_req(0, mk(MEM_LW, 32'h0001_0000, 32'h0), 32'h0, 1, 0, 0);
        run_req(0, mk(MEM_LW, 32'h0001_0002, 32'h0), 32'h0, 1, 0, 0);
        run_req(0, mk(MEM_SW, 32'hFFFF_FFFC, 32'h1111_1111), 32'h0, 1, 0, 0);
        checks++;
        if (en_cnt1 !== en_before) begin
            errors++;
            $display("FAIL fault_ram_enable: %0d RAM enables during faulting requests, want 0",
                     en_cnt1 - en_before);
        end
        run_req(0, mk(MEM_LW, 32'h0000_FFFC, 32'h0), 32'hCAFE_F00D, 0, 0, 0);
    endtask

    task automatic test_base_window();
        memory_request_t r;
        r = mk(MEM_SW, 32'h0000_1FFC, 32'h5A5A_0F0F);
        run_req(1, r, mdl_exec(r), 0, 0, 0);
        r = mk(MEM_LW, 32'h0000_1FFC, 32'h0);
        run_req(1, r, mdl_exec(r), 0, 0, 0);
        run_req(1, mk(MEM_LW, 32'h0000_0FFC, 32'h0), 32'h0, 1, 0, 0);
        run_req(1, mk(MEM_LW, 32'h0000_2000, 32'h0), 32'h0, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        memory_request_t stream [11];
        int done_before, en_before, prev_cyc;
        stream[0]  = mk(MEM_SW,  32'h1200, 32'h0123_4567);
        stream[1]  = mk(MEM_SW,  32'h1204, 32'h89AB_CDEF);
        stream[2]  = mk(MEM_SW,  32'h1204, 32'h89AB_CDEF);
        stream[3]  = mk(MEM_LW,  32'h1200, 32'h0);
        stream[4]  = mk(MEM_LW,  32'h1204, 32'h0);
        stream[5]  = mk(MEM_SB,  32'h1205, 32'h0000_007F);
        stream[6]  = mk(MEM_LH,  32'h1204, 32'h0);
        stream[7]  = mk(MEM_LB,  32'h1207, 32'h0);
        stream[8]  = mk(MEM_SH,  32'h1202, 32'h0000_BEEF);
        stream[9]  = mk(MEM_LW,  32'h1200, 32'h0);
        stream[10] = mk(MEM_LHU, 32'h1202, 32'h0);
        done_before = done_cnt3;
        en_before   = en_cnt3;
        prev_cyc    = 0;
        for (int i = 0; i < 11; i++) begin
            run_req(1, stream[i], mdl_exec(stream[i]), 0, 0, i != 10);
            if (i > 0) begin
                checks++;
                if (last_done_cyc - prev_cyc !== 5) begin
                    errors++;
                    $display("FAIL done_period req%0d: got %0d cycles between dones, want 5",
                             i, last_done_cyc - prev_cyc);
                end
            end
            prev_cyc = last_done_cyc;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt3 - done_before !== 11 || en_cnt3 - en_before !== 11) begin
            errors++;
            $display("FAIL exec_once: got %0d dones and %0d RAM accesses, want 11 and 11",
                     done_cnt3 - done_before, en_cnt3 - en_before);
        end
    endtask

    task automatic test_reset_abort();
        int done_before, en_before;
        run_req(1, mk(MEM_SW, 32'h1100, 32'h1111_1111), 32'h0, 0, 0, 0);
        void'(mdl_exec(mk(MEM_SW, 32'h1100, 32'h1111_1111)));
        @(negedge clk);
        done_before = done_cnt3;
        en_before   = en_cnt3;
        req3 = mk(MEM_SW, 32'h1100, 32'h2222_2222);
        repeat (2) @(negedge clk);
        resetn3 = 1'b0;
        req3 = mk(MEM_NOP, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (2'(dut3.state_q) !== 2'd0 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: state=%0d done=%b after reset in BUSY, want IDLE and 0",
                     dut3.state_q, done3);
        end
        resetn3 = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt3 !== done_before || en_cnt3 !== en_before) begin
            errors++;
            $display("FAIL abort_no_access: got %0d dones and %0d RAM accesses, want 0 and 0",
                     done_cnt3 - done_before, en_cnt3 - en_before);
        end
        run_req(1, mk(MEM_LW, 32'h1100, 32'h0), 32'h1111_1111, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_misaligned();
        test_fault();
        test_base_window();
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
